// File: rtl/pkg_opengpu.sv
// Shared widths and types for the FP FMA operand collector.
package pkg_opengpu;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    FMA_OP_MADD = 1'b0,
    FMA_OP_MSUB = 1'b1
  } fma_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_RD_C  = 3'd3,
    ST_CAP_C = 3'd4,
    ST_ISSUE = 3'd5
  } collector_state_e;

  // Latched request payload held for the whole collection/issue sequence.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rs3;
    logic [REG_ADDR_W-1:0] rd;
    fma_op_e               op;
  } fma_req_t;

endpackage

// File: rtl/fpu_fma_operand_collector.sv
// Collects rs1/rs2/rs3 over one synchronous RF read port and issues them to the FMA unit.
module fpu_fma_operand_collector
  import pkg_opengpu::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [REG_ADDR_W-1:0] req_rs1,
  input  logic [REG_ADDR_W-1:0] req_rs2,
  input  logic [REG_ADDR_W-1:0] req_rs3,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic                  rf_rd_en,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic                  out_negate_c,
  output logic [REG_ADDR_W-1:0] out_rd
);

  collector_state_e      state;
  collector_state_e      next_state;
  fma_req_t              req_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] c_q;

  logic                  accept;
  logic                  cap_a;
  logic                  cap_b;
  logic                  cap_c;
  logic                  rd_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_d;
  logic [REG_ADDR_W-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, handshake, capture strobes and the next RF read request.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_c      = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = rf_rd_addr;

    if (flush) begin
      // Flush wins: no accept, no capture, pending read data is dropped.
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) next_state = ST_RD_A;
        end
        ST_RD_A: begin
          next_state = ST_RD_B;
        end
        ST_RD_B: begin
          cap_a      = 1'b1;
          next_state = ST_RD_C;
        end
        ST_RD_C: begin
          cap_b      = 1'b1;
          next_state = ST_CAP_C;
        end
        ST_CAP_C: begin
          cap_c      = 1'b1;
          next_state = ST_ISSUE;
        end
        ST_ISSUE: begin
          req_ready = out_ready;
          if (out_ready) next_state = req_valid ? ST_RD_A : ST_IDLE;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end

    accept = req_valid && req_ready;

    // Read strobe/address are registered, so they are derived from the state being entered.
    unique case (next_state)
      ST_RD_A: begin
        rd_en_d   = 1'b1;
        rd_addr_d = req_rs1;
      end
      ST_RD_B: begin
        rd_en_d   = 1'b1;
        rd_addr_d = req_q.rs2;
      end
      ST_RD_C: begin
        rd_en_d   = 1'b1;
        rd_addr_d = req_q.rs3;
      end
      default: begin
        rd_en_d   = 1'b0;
        rd_addr_d = rf_rd_addr;
      end
    endcase
  end

  // Capture mux: a same-cycle writeback to the register being captured overrides RF data.
  always_comb begin
    cap_addr = req_q.rs3;
    if (cap_a) begin
      cap_addr = req_q.rs1;
    end else if (cap_b) begin
      cap_addr = req_q.rs2;
    end
    cap_data = (wb_valid && (wb_addr == cap_addr)) ? wb_data : rf_rd_data;
  end

  // Request latch, operand capture and registered RF/issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        req_q.rs1 <= req_rs1;
        req_q.rs2 <= req_rs2;
        req_q.rs3 <= req_rs3;
        req_q.rd  <= req_rd;
        req_q.op  <= fma_op_e'(req_op);
      end
      if (cap_a) a_q <= cap_data;
      if (cap_b) b_q <= cap_data;
      if (cap_c) c_q <= cap_data;
      rf_rd_en   <= rd_en_d;
      rf_rd_addr <= rd_addr_d;
      out_valid  <= (next_state == ST_ISSUE);
    end
  end

  // Issue payload comes straight from the captured registers.
  always_comb begin
    out_a        = a_q;
    out_b        = b_q;
    out_c        = c_q;
    out_rd       = req_q.rd;
    out_negate_c = (req_q.op == FMA_OP_MSUB);
  end

endmodule
